// File: rtl/fp16_pkg.sv
// rtl/fp16_pkg.sv - float16 result class constants and shared result types
package fp16_pkg;

  localparam int TYPE_NORM    = 5;
  localparam int TYPE_SUB     = 4;
  localparam int TYPE_ZERO    = 3;
  localparam int TYPE_EXT_MSB = 2;
  localparam int TYPE_EXT_LSB = 0;

  typedef struct packed {
    logic [5:0]  typ;
    logic [15:0] data;
  } fp16_result_t;

  typedef struct packed {
    logic         last;
    fp16_result_t res;
  } drain_entry_t;

  function automatic logic is_ext_class(input logic [5:0] t);
    return |t[TYPE_EXT_MSB:TYPE_EXT_LSB];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with explicit level counter
// Head data reads zero while empty; storage itself is never reset.
module sync_fifo #(
  parameter int WIDTH = 23,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push_i && !pop_i)      level_d = level_q + 1'b1;
      else if (pop_i && !push_i) level_d = level_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // When full with a same-cycle pop, wr_ptr equals rd_ptr: the head is read before this edge overwrites it.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == FULL_LEVEL);
  assign level_o = level_q;
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/acc_drain.sv
// rtl/acc_drain.sv - accumulator result drain buffer with frame marking and sticky flags
module acc_drain
  import fp16_pkg::*;
#(
  parameter int         DEPTH     = 8,
  parameter logic [5:0] FRAME_LEN = 6'd2
) (
  input  logic                   CLK,
  input  logic                   RSTn,
  input  logic                   DVI,
  input  logic [5:0]             DI_TYPE,
  input  logic [15:0]            DI,
  input  logic                   CLR,
  output logic                   OUT_VALID,
  input  logic                   OUT_READY,
  output logic [15:0]            OUT_DATA,
  output logic [5:0]             OUT_TYPE,
  output logic                   OUT_LAST,
  output logic [$clog2(DEPTH):0] LEVEL,
  output logic                   OVF,
  output logic                   EXC
);

  logic         pop, push, full, empty, last_bit;
  drain_entry_t wr_entry, rd_entry;
  logic [5:0]   frm_cnt_q, frm_cnt_d;
  logic         ovf_q, ovf_d;
  logic         exc_q, exc_d;

  // Full plus a simultaneous pop still accepts the write, since the accumulator cannot stall.
  assign pop      = OUT_VALID && OUT_READY && !CLR;
  assign push     = DVI && !CLR && (!full || pop);
  assign last_bit = (frm_cnt_q == FRAME_LEN - 6'd1);

  always_comb begin
    wr_entry          = '0;
    wr_entry.last     = last_bit;
    wr_entry.res.typ  = DI_TYPE;
    wr_entry.res.data = DI;
  end

  always_comb begin
    frm_cnt_d = frm_cnt_q;
    ovf_d     = ovf_q;
    exc_d     = exc_q;
    if (CLR) begin
      frm_cnt_d = '0;
      ovf_d     = 1'b0;
      exc_d     = 1'b0;
    end else begin
      if (push) frm_cnt_d = last_bit ? 6'd0 : frm_cnt_q + 6'd1;
      if (push && is_ext_class(DI_TYPE)) exc_d = 1'b1;
      if (DVI && !push) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      frm_cnt_q <= '0;
      ovf_q     <= 1'b0;
      exc_q     <= 1'b0;
    end else begin
      frm_cnt_q <= frm_cnt_d;
      ovf_q     <= ovf_d;
      exc_q     <= exc_d;
    end
  end

  sync_fifo #(
    .WIDTH($bits(drain_entry_t)),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk     (CLK),
    .rst_n   (RSTn),
    .clr_i   (CLR),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (wr_entry),
    .rdata_o (rd_entry),
    .full_o  (full),
    .empty_o (empty),
    .level_o (LEVEL)
  );

  assign OUT_VALID = !empty;
  assign OUT_DATA  = rd_entry.res.data;
  assign OUT_TYPE  = rd_entry.res.typ;
  assign OUT_LAST  = rd_entry.last;
  assign OVF       = ovf_q;
  assign EXC       = exc_q;

endmodule

// File: tb/tb_acc_drain.sv
// tb/tb_acc_drain.sv - scoreboard bench for acc_drain
module tb_acc_drain;

  logic        CLK = 1'b0;
  logic        RSTn, DVI, CLR, OUT_READY;
  logic [5:0]  DI_TYPE;
  logic [15:0] DI;
  logic        OUT_VALID, OUT_LAST, OVF, EXC;
  logic [15:0] OUT_DATA;
  logic [5:0]  OUT_TYPE;
  logic [3:0]  LEVEL;

  int          errors = 0;
  int          checks = 0;
  logic [22:0] exp_q[$];
  logic [22:0] sb_e;

  acc_drain #(.DEPTH(8), .FRAME_LEN(6'd2)) dut (
    .CLK(CLK), .RSTn(RSTn), .DVI(DVI), .DI_TYPE(DI_TYPE), .DI(DI), .CLR(CLR),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA),
    .OUT_TYPE(OUT_TYPE), .OUT_LAST(OUT_LAST), .LEVEL(LEVEL), .OVF(OVF), .EXC(EXC)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [5:0] t, input logic [15:0] d, input logic accepted, input logic last);
    DVI     = 1'b1;
    DI_TYPE = t;
    DI      = d;
    if (accepted) exp_q.push_back({last, t, d});
    step();
    DVI = 1'b0;
  endtask

  // Monitor: every handshake pops the scoreboard and compares the head entry.
  always @(negedge CLK) begin
    if (RSTn && OUT_VALID && OUT_READY && !CLR) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got %0h expected none", {OUT_LAST, OUT_TYPE, OUT_DATA});
      end else begin
        sb_e = exp_q.pop_front();
        chk("sb_head", {9'd0, OUT_LAST, OUT_TYPE, OUT_DATA}, {9'd0, sb_e});
      end
    end
  end

  initial begin
    RSTn = 1'b0; DVI = 1'b0; CLR = 1'b0; OUT_READY = 1'b0; DI = '0; DI_TYPE = '0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_valid", OUT_VALID, 0);
    chk("rst_data",  OUT_DATA, 0);
    chk("rst_type",  OUT_TYPE, 0);
    chk("rst_last",  OUT_LAST, 0);
    chk("rst_level", LEVEL, 0);
    chk("rst_ovf",   OVF, 0);
    chk("rst_exc",   EXC, 0);
    RSTn = 1'b1;
    step();

    OUT_READY = 1'b1;
    send(6'b100000, 16'h3C00, 1'b1, 1'b0);
    chk("single_valid", OUT_VALID, 1);
    chk("single_data",  OUT_DATA, 16'h3C00);
    chk("single_last",  OUT_LAST, 0);
    send(6'b100000, 16'h4000, 1'b1, 1'b1);
    chk("second_last", OUT_LAST, 1);
    step();
    chk("single_drained", LEVEL, 0);

    OUT_READY = 1'b0;
    for (int i = 0; i < 8; i++) send(6'b100000, 16'h1000 + 16'(i), 1'b1, (i % 2) == 1);
    chk("fill_level", LEVEL, 8);
    chk("fill_ovf",   OVF, 0);

    OUT_READY = 1'b1;
    send(6'b100000, 16'h1008, 1'b1, 1'b0);
    OUT_READY = 1'b0;
    chk("fullpop_level", LEVEL, 8);
    chk("fullpop_ovf",   OVF, 0);

    send(6'b100000, 16'hDEAD, 1'b0, 1'b0);
    chk("ovf_set",   OVF, 1);
    chk("ovf_level", LEVEL, 8);

    OUT_READY = 1'b1;
    repeat (8) step();
    chk("drain_level", LEVEL, 0);
    chk("drain_valid", OUT_VALID, 0);
    send(6'b100000, 16'h1009, 1'b1, 1'b1);
    step();

    send(6'b000001, 16'h7C00, 1'b1, 1'b0);
    chk("exc_set", EXC, 1);
    send(6'b100000, 16'h3C00, 1'b1, 1'b1);
    step();
    chk("exc_hold", EXC, 1);
    chk("ovf_hold", OVF, 1);
    CLR = 1'b1;
    step();
    CLR = 1'b0;
    chk("clr_exc", EXC, 0);
    chk("clr_ovf", OVF, 0);

    OUT_READY = 1'b0;
    send(6'b100000, 16'h1111, 1'b1, 1'b0);
    send(6'b000010, 16'h7E00, 1'b1, 1'b1);
    send(6'b001000, 16'h0000, 1'b1, 1'b0);
    chk("pre_clr_level", LEVEL, 3);
    chk("pre_clr_exc",   EXC, 1);
    CLR = 1'b1; DVI = 1'b1; DI = 16'hBEEF; DI_TYPE = 6'b100000; OUT_READY = 1'b1;
    step();
    CLR = 1'b0; DVI = 1'b0;
    exp_q.delete();
    chk("clr_level", LEVEL, 0);
    chk("clr_valid", OUT_VALID, 0);
    chk("clr_ovf2",  OVF, 0);
    chk("clr_exc2",  EXC, 0);
    send(6'b100000, 16'h2222, 1'b1, 1'b0);
    send(6'b100000, 16'h3333, 1'b1, 1'b1);
    step();

    OUT_READY = 1'b0;
    send(6'b010000, 16'h4444, 1'b1, 1'b0);
    send(6'b100000, 16'h5555, 1'b1, 1'b1);
    chk("pre_rst_level", LEVEL, 2);
    #3 RSTn = 1'b0;
    #2;
    exp_q.delete();
    chk("arst_valid", OUT_VALID, 0);
    chk("arst_data",  OUT_DATA, 0);
    chk("arst_type",  OUT_TYPE, 0);
    chk("arst_last",  OUT_LAST, 0);
    chk("arst_level", LEVEL, 0);
    chk("arst_ovf",   OVF, 0);
    chk("arst_exc",   EXC, 0);
    @(posedge CLK);
    #3 RSTn = 1'b1;
    OUT_READY = 1'b1;
    repeat (2) step();
    chk("post_rst_valid", OUT_VALID, 0);
    chk("post_rst_data",  OUT_DATA, 0);
    chk("post_rst_level", LEVEL, 0);
    send(6'b100000, 16'h6666, 1'b1, 1'b0);
    chk("post_rst_first", OUT_VALID, 1);
    repeat (2) step();

    chk("sb_empty",  exp_q.size(), 0);
    chk("end_level", LEVEL, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/acc_drain.md
# acc_drain

Result drain buffer placed directly downstream of the float16 accumulator. It captures each accumulator result (`DVO`/`DO`/`DO_TYPE`), which cannot be stalled, into a small FIFO. It presents the results on a valid/ready stream with frame delimiting and sticky status flags, so the array's results can be read by a bus master or DMA that applies backpressure.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries; power of two, 2..64.
- `FRAME_LEN`, 6'd2: results per output frame; `OUT_LAST` marks the final result of each frame; range 1..63.

Ports:
- `CLK`  in  1  clock; single clock domain.
- `RSTn`  in  1  reset; asynchronous, active-low.
- `DVI`  in  1  result valid from the accumulator's `DVO`; single-cycle pulses, possibly back-to-back.
- `DI_TYPE`  in  6  result class from `DO_TYPE`.
- `DI`  in  16  float16 result from `DO`.
- `CLR`  in  1  synchronous flush: empties the FIFO, zeroes counters, clears sticky flags.
- `OUT_VALID`  out  1  stream valid.
- `OUT_READY`  in  1  stream ready.
- `OUT_DATA`  out  16  head result.
- `OUT_TYPE`  out  6  head class.
- `OUT_LAST`  out  1  head is the last result of a frame.
- `LEVEL`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `OVF`  out  1  sticky: a result was dropped.
- `EXC`  out  1  sticky: a result with non-zero `DI_TYPE[2:0]` (inf/NaN class) was accepted.

## Operation
- Class bits:
  - [5] is the normal (hidden-bit) class.
  - [4] is the subnormal class.
  - [3] is the zero class.
  - [2:0] non-zero marks the extreme (inf/NaN) class.
- The block stores class bits unmodified. Only [2:0] is inspected, for `EXC`.
- Write rules:
  - On `DVI`, write {`DI_TYPE`, `DI`, last}.
  - The write happens if the FIFO is not full, or if it is full and a pop occurs in the same cycle. A full FIFO with a simultaneous pop accepts the write.
  - Otherwise the result is dropped and `OVF` is set.
- Frame counter:
  - `frm_cnt` (6 bits) advances only on accepted writes and wraps at `FRAME_LEN-1`.
  - The `last` bit for an entry is (`frm_cnt == FRAME_LEN-1`).
  - A dropped result does not advance the counter, so frames stay aligned to stored data.
- Read rules:
  - A pop occurs when `OUT_VALID && OUT_READY`.
  - `OUT_*` always reflect the head entry.
  - `OUT_VALID = (LEVEL != 0)`.
- Pointers are $clog2(DEPTH) bits and wrap naturally. `LEVEL` is an explicit counter:
  - +1 on write only.
  - −1 on pop only.
  - Unchanged when both occur in the same cycle.
- `EXC` is set on any accepted write with `DI_TYPE[2:0] != 0`.
- `CLR` has priority over `DVI` and pop in the same cycle. The `DVI` sample in the clear cycle is discarded and does not set `OVF`.
- There is no FSM beyond the FIFO; status is the empty/partial/full occupancy.

## Timing
- Reset values: `OUT_VALID`=0, `OUT_DATA`=0, `OUT_TYPE`=0, `OUT_LAST`=0, `LEVEL`=0, `OVF`=0, `EXC`=0. Pointers and `frm_cnt` also reset to 0.
- Latency: `DVI` at edge n into an empty FIFO gives `OUT_VALID`=1 with that data after edge n (one cycle). There is no combinational path from `DVI` to `OUT_*`.
- `OUT_VALID` and `OUT_*` stay stable until accepted. `OUT_VALID` never drops without a pop, except through `CLR` or reset.
- `OUT_READY` may be asserted while `OUT_VALID` is low; this has no effect.
- Throughput: one write and one pop per cycle are sustained at any level.
- Reset mid-operation discards all contents immediately (asynchronous). The FIFO storage array itself needs no reset; head outputs read 0 while empty.
- `OVF` and `EXC` remain set until `CLR` or reset.

## Structure
- The shared package `fp16_pkg` holds:
  - class-bit index constants: `TYPE_NORM`=5, `TYPE_SUB`=4, `TYPE_ZERO`=3, `TYPE_EXT`=2:0;
  - the `fp16_result_t` struct {type[5:0], data[15:0]} shared with the accumulator.
- Sub-module `sync_fifo`, parameterised by width and depth, with push/pop/full/empty/level. `acc_drain` wraps it with the drop, frame and flag logic.

## Test plan
- Single result: `DVI` with `DI`=16'h3C00, `DI_TYPE`=6'b100000, `OUT_READY`=1 → next cycle `OUT_VALID`=1, `OUT_DATA`=3C00, `OUT_LAST`=0 (`FRAME_LEN`=2). A second result gives `OUT_LAST`=1.
- Fill with backpressure: `OUT_READY`=0, 8 back-to-back `DVI` (`DEPTH`=8) → `LEVEL`=8. A ninth `DVI` sets `OVF`=1 with `LEVEL` still 8, and `frm_cnt` is not advanced. Draining returns data in order with `OUT_LAST` on entries 2, 4, 6, 8.
- Full plus simultaneous pop: with `LEVEL`=8, `OUT_READY`=1 and `DVI` in the same cycle → the write is accepted, `LEVEL` stays 8, and `OVF` stays 0.
- Exception: accept `DI`=16'h7C00 with `DI_TYPE`=6'b000001 → `EXC`=1. It holds through a subsequent normal result and clears on `CLR`.
- `CLR` with concurrent `DVI` and pop at `LEVEL`=3 → next cycle `LEVEL`=0, `OUT_VALID`=0, `OVF`=0, `EXC`=0, and the frame restarts at `frm_cnt`=0.
- Async reset asserted mid-stream between clock edges → all outputs read 0 immediately, and they stay 0 until the first `DVI` after `RSTn` is released.
